// File: rtl/vga_fb_scanout.sv
// rtl/vga_fb_scanout.sv - VGA scan-out engine with scaling, packed pixels and tear-free page flip
//
// Ports:
//   clk          rising-edge system clock
//   rst_n        synchronous reset, active-low
//   pix_en       pixel tick; counters and pipeline advance only when high
//   fb_base      new frame base word address
//   fb_base_wr   one-cycle strobe, captures fb_base as pending base
//   mem_addr     frame RAM port-B word address (registered)
//   mem_rdata    frame RAM port-B read data (RAM_LAT clk after address)
//   hsync/vsync  sync outputs, active level SYNC_POL
//   color        pixel value, 0 outside the active area
//   active       high when color is a visible pixel
//   frame_start  one-clk pulse on the tick where counters sit at (0,0)
//   flip_done    one-clk pulse when a pending base is applied
module vga_fb_scanout #(
    parameter int          H_ACTIVE    = 640,
    parameter int          H_FP        = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BP        = 48,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_FP        = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BP        = 33,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int          SCALE_SHIFT = 2,
    parameter int          ADDR_W      = 15,
    parameter int          DATA_W      = 16,
    parameter int          PIX_W       = 8,
    parameter int          RAM_LAT     = 1,
    parameter int unsigned BASE_RST    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic              fb_base_wr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              hsync,
    output logic              vsync,
    output logic [PIX_W-1:0]  color,
    output logic              active,
    output logic              frame_start,
    output logic              flip_done
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W     = $clog2(H_TOTAL);
    localparam int VC_W     = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int PACK     = DATA_W / PIX_W;
    localparam int PACK_SH  = $clog2(PACK);
    localparam int LANE_W   = (PACK_SH > 0) ? PACK_SH : 1;
    localparam int WPR      = (H_ACTIVE >> SCALE_SHIFT) / PACK;

    localparam logic [HC_W-1:0]   H_LAST     = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0]   V_LAST     = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0]   V_SUB_MASK = VC_W'((1 << SCALE_SHIFT) - 1);
    localparam logic [HC_W-1:0]   LANE_MASK  = HC_W'(PACK - 1);
    localparam logic [ADDR_W-1:0] BASE_INIT  = ADDR_W'(BASE_RST);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(WPR);
    localparam logic [1:0]        SLOT_LAST  = 2'(RAM_LAT);

    logic [HC_W-1:0]   r_h;
    logic [VC_W-1:0]   r_v;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_pend_base;
    logic              r_pending;
    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_mem_addr;

    // Sideband stages travelling alongside the RAM access, one per tick.
    logic              r_s_vis  [0:RAM_LAT];
    logic              r_s_hs   [0:RAM_LAT];
    logic              r_s_vs   [0:RAM_LAT];
    logic [LANE_W-1:0] r_s_lane [0:RAM_LAT];

    // The RAM runs on every clk, but ticks may be sparse. Each issued address
    // carries a slot tag (tick number mod RAM_LAT+1); its data is parked in
    // that slot exactly RAM_LAT+1 clk after issue. The output tick that
    // consumes it has the same slot number, so it reads the parked word, or
    // takes mem_rdata directly when the data lands on that very edge.
    logic              r_pe_sh  [0:RAM_LAT];
    logic [1:0]        r_tag_sh [0:RAM_LAT];
    logic [1:0]        r_slot;
    logic [DATA_W-1:0] r_buf    [0:3];

    logic              r_hsync;
    logic              r_vsync;
    logic              r_active;
    logic [PIX_W-1:0]  r_color;
    logic              r_frame_start;
    logic              r_flip_done;

    logic              w_line_end;
    logic              w_frame_end;
    logic              w_row_step;
    logic              w_flip_req;
    logic [ADDR_W-1:0] w_flip_val;
    logic              w_flip_now;
    logic [ADDR_W-1:0] w_base_next;
    logic [HC_W-1:0]   w_px;
    logic [ADDR_W-1:0] w_addr;
    logic [LANE_W-1:0] w_lane;
    logic              w_vis;
    logic              w_hs_on;
    logic              w_vs_on;
    logic              w_fresh;
    logic              w_bypass;
    logic [DATA_W-1:0] w_data;
    logic [PIX_W-1:0]  w_pix;

    assign w_line_end  = (r_h == H_LAST);
    assign w_frame_end = w_line_end && (r_v == V_LAST);
    assign w_row_step  = w_line_end && ((r_v & V_SUB_MASK) == V_SUB_MASK)
                         && (int'(r_v) < V_ACTIVE);

    // A write landing on the wrap tick itself wins over any older pending value.
    assign w_flip_req  = fb_base_wr || r_pending;
    assign w_flip_val  = fb_base_wr ? fb_base : r_pend_base;
    assign w_flip_now  = pix_en && w_frame_end && w_flip_req;
    assign w_base_next = w_flip_now ? w_flip_val : r_base;

    assign w_px    = r_h >> SCALE_SHIFT;
    assign w_addr  = r_row + ADDR_W'(w_px >> PACK_SH);
    assign w_lane  = LANE_W'(w_px & LANE_MASK);
    assign w_vis   = (int'(r_h) < H_ACTIVE) && (int'(r_v) < V_ACTIVE);
    assign w_hs_on = (int'(r_h) >= HS_START) && (int'(r_h) < HS_END);
    assign w_vs_on = (int'(r_v) >= VS_START) && (int'(r_v) < VS_END);

    assign w_fresh  = r_pe_sh[RAM_LAT];
    assign w_bypass = w_fresh && (r_tag_sh[RAM_LAT] == r_slot);
    assign w_data   = w_bypass ? mem_rdata : r_buf[r_slot];
    assign w_pix    = w_data[int'(r_s_lane[RAM_LAT]) * PIX_W +: PIX_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h           <= '0;
            r_v           <= '0;
            r_base        <= BASE_INIT;
            r_pend_base   <= BASE_INIT;
            r_pending     <= 1'b0;
            r_row         <= BASE_INIT;
            r_mem_addr    <= BASE_INIT;
            r_slot        <= '0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_active      <= 1'b0;
            r_color       <= '0;
            r_frame_start <= 1'b0;
            r_flip_done   <= 1'b0;
            for (int i = 0; i <= RAM_LAT; i++) begin
                r_s_vis[i]  <= 1'b0;
                r_s_hs[i]   <= 1'b0;
                r_s_vs[i]   <= 1'b0;
                r_s_lane[i] <= '0;
                r_pe_sh[i]  <= 1'b0;
                r_tag_sh[i] <= '0;
            end
        end else begin
            if (w_flip_now) begin
                r_base    <= w_flip_val;
                r_pending <= 1'b0;
            end else if (fb_base_wr) begin
                r_pend_base <= fb_base;
                r_pending   <= 1'b1;
            end
            r_flip_done   <= w_flip_now;
            r_frame_start <= pix_en && (r_h == '0) && (r_v == '0);

            r_pe_sh[0]  <= pix_en;
            r_tag_sh[0] <= r_slot;
            for (int i = 1; i <= RAM_LAT; i++) begin
                r_pe_sh[i]  <= r_pe_sh[i-1];
                r_tag_sh[i] <= r_tag_sh[i-1];
            end

            if (pix_en) begin
                if (w_line_end) begin
                    r_h <= '0;
                    r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
                end else begin
                    r_h <= r_h + 1'b1;
                end

                if (w_frame_end) begin
                    r_row <= w_base_next;
                end else if (w_row_step) begin
                    r_row <= r_row + ROW_STEP;
                end

                r_mem_addr  <= w_addr;
                r_slot      <= (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;

                r_s_vis[0]  <= w_vis;
                r_s_hs[0]   <= w_hs_on;
                r_s_vs[0]   <= w_vs_on;
                r_s_lane[0] <= w_lane;
                for (int i = 1; i <= RAM_LAT; i++) begin
                    r_s_vis[i]  <= r_s_vis[i-1];
                    r_s_hs[i]   <= r_s_hs[i-1];
                    r_s_vs[i]   <= r_s_vs[i-1];
                    r_s_lane[i] <= r_s_lane[i-1];
                end

                r_hsync  <= r_s_hs[RAM_LAT] ? SYNC_POL : ~SYNC_POL;
                r_vsync  <= r_s_vs[RAM_LAT] ? SYNC_POL : ~SYNC_POL;
                r_active <= r_s_vis[RAM_LAT];
                r_color  <= r_s_vis[RAM_LAT] ? w_pix : '0;
            end
        end
    end

    // Parking slots hold only in-flight data; no reset needed.
    always_ff @(posedge clk) begin
        if (w_fresh) begin
            r_buf[r_tag_sh[RAM_LAT]] <= mem_rdata;
        end
    end

    assign mem_addr    = r_mem_addr;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;
    assign color       = r_color;
    assign frame_start = r_frame_start;
    assign flip_done   = r_flip_done;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb/tb_vga_fb_scanout.sv - directed self-checking bench for vga_fb_scanout
module tb_vga_fb_scanout;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_en;
    logic [14:0] fb_base;
    logic        fb_base_wr;
    logic [14:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        hsync;
    logic        vsync;
    logic [7:0]  color;
    logic        active;
    logic        frame_start;
    logic        flip_done;

    int checks   = 0;
    int failures = 0;

    // Visible colors per framebuffer row pair, for a base with low byte 0x00
    // and for base 0x7FFF (which wraps to word 0x0000 mid-row).
    logic [7:0] tbl_lo [0:1][0:7] = '{
        '{8'h00, 8'h00, 8'h80, 8'h80, 8'h01, 8'h01, 8'h81, 8'h81},
        '{8'h02, 8'h02, 8'h82, 8'h82, 8'h03, 8'h03, 8'h83, 8'h83}};
    logic [7:0] tbl_hi [0:1][0:7] = '{
        '{8'hFF, 8'hFF, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'h80, 8'h80},
        '{8'h01, 8'h01, 8'h81, 8'h81, 8'h02, 8'h02, 8'h82, 8'h82}};

    always #5 clk = ~clk;

    // One-cycle-latency RAM: word[n] = {n+0x80, n}.
    always @(posedge clk) mem_rdata <= {mem_addr[7:0] + 8'h80, mem_addr[7:0]};

    vga_fb_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .SCALE_SHIFT(1), .ADDR_W(15), .DATA_W(16),
        .PIX_W(8), .RAM_LAT(1), .BASE_RST(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .fb_base(fb_base), .fb_base_wr(fb_base_wr),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .hsync(hsync), .vsync(vsync), .color(color), .active(active),
        .frame_start(frame_start), .flip_done(flip_done)
    );

    task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at m=%0d: observed=%0h expected=%0h", tag, m, obs, exp);
        end
    endtask

    // p is the scan position shown at the outputs; negative means still reset values.
    task automatic chk_video(input int m, input int p, input bit hi);
        int h;
        int v;
        logic ea;
        logic [7:0] ec;
        if (p < 0) begin
            chk("hsync_idle", m, 32'(hsync), 32'd1);
            chk("vsync_idle", m, 32'(vsync), 32'd1);
            chk("active_idle", m, 32'(active), 32'd0);
            chk("color_idle", m, 32'(color), 32'd0);
        end else begin
            h  = p % 14;
            v  = (p / 14) % 7;
            ea = (h < 8) && (v < 4);
            ec = 8'h00;
            if (ea) ec = hi ? tbl_hi[v >> 1][h] : tbl_lo[v >> 1][h];
            chk("hsync", m, 32'(hsync), (h == 10 || h == 11) ? 32'd0 : 32'd1);
            chk("vsync", m, 32'(vsync), (v == 5) ? 32'd0 : 32'd1);
            chk("active", m, 32'(active), 32'(ea));
            chk("color", m, 32'(color), 32'(ec));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        pix_en     = 1'b1;
        fb_base    = '0;
        fb_base_wr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Short run with a pending write, then reset at h=5 mid-line.
        for (int m = 1; m <= 5; m++) begin
            @(negedge clk);
            fb_base_wr = (m == 2);
            fb_base    = 15'h0555;
        end
        fb_base_wr = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        chk("rst_hsync", 0, 32'(hsync), 32'd1);
        chk("rst_vsync", 0, 32'(vsync), 32'd1);
        chk("rst_color", 0, 32'(color), 32'd0);
        chk("rst_active", 0, 32'(active), 32'd0);
        chk("rst_mem_addr", 0, 32'(mem_addr), 32'd0);
        chk("rst_frame_start", 0, 32'(frame_start), 32'd0);
        chk("rst_flip_done", 0, 32'(flip_done), 32'd0);
        rst_n = 1'b1;

        // Continuous pixel clock: four frames with three page flips.
        for (int m = 1; m <= 400; m++) begin
            @(negedge clk);
            chk_video(m, m - 3, 1'b0);
            chk("frame_start", m, 32'(frame_start), ((m - 1) % 98 == 0) ? 32'd1 : 32'd0);
            chk("flip_done", m, 32'(flip_done),
                (m == 196 || m == 294 || m == 392) ? 32'd1 : 32'd0);
            case (m)
                5:   chk("addr_h4",          m, 32'(mem_addr), 32'h0001);
                99:  chk("addr_no_stale",    m, 32'(mem_addr), 32'h0000);
                127: chk("addr_line2_old",   m, 32'(mem_addr), 32'h0002);
                197: chk("addr_flip_100",    m, 32'(mem_addr), 32'h0100);
                225: chk("addr_line2_new",   m, 32'(mem_addr), 32'h0102);
                295: chk("addr_last_wins",   m, 32'(mem_addr), 32'h0300);
                393: chk("addr_wrap_write",  m, 32'(mem_addr), 32'h0400);
                default: ;
            endcase
            fb_base_wr = 1'b0;
            if (m == 126) begin fb_base_wr = 1'b1; fb_base = 15'h0100; end
            if (m == 230) begin fb_base_wr = 1'b1; fb_base = 15'h0200; end
            if (m == 250) begin fb_base_wr = 1'b1; fb_base = 15'h0300; end
            if (m == 391) begin fb_base_wr = 1'b1; fb_base = 15'h0400; end
        end

        // Pixel tick every third clk, then flip to base 0x7FFF.
        fb_base_wr = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        pix_en = 1'b1;
        for (int m = 1; m <= 600; m++) begin
            @(negedge clk);
            chk_video(m, (m >= 7) ? (m - 7) / 3 : -1, (m >= 7) && ((m - 7) / 3 >= 98));
            chk("g_frame_start", m, 32'(frame_start), ((m - 1) % 294 == 0) ? 32'd1 : 32'd0);
            chk("g_flip_done", m, 32'(flip_done), (m == 292) ? 32'd1 : 32'd0);
            if (m <= 3)
                chk("g_addr_base0", m, 32'(mem_addr), 32'h0000);
            if (m >= 295 && m <= 297)
                chk("g_addr_7fff", m, 32'(mem_addr), 32'h7FFF);
            if (m >= 307 && m <= 309)
                chk("g_addr_wrap0", m, 32'(mem_addr), 32'h0000);
            if (m == 379)
                chk("g_addr_line2", m, 32'(mem_addr), 32'h0001);
            pix_en     = (m % 3 == 0);
            fb_base_wr = (m == 3);
            fb_base    = 15'h7FFF;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
- Parametrised VGA scan-out engine; successor to the fixed 640x480, one-byte-per-word VGA controller.
- Generates programmable sync timing and reads pixels from port B of the shared dual-port frame RAM.
- Adds integer pixel replication (2^SCALE_SHIFT), multiple pixels packed per RAM word, and double-buffered base address with tear-free page flip at the frame boundary.
- Sits between the frame RAM read port and the board DAC pins; the core writes frames through port A.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 96, hsync width (ticks)
H_BP, 48, horizontal back porch (ticks)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)
SCALE_SHIFT, 2, each framebuffer pixel is replicated 2^S x 2^S; FB_W = H_ACTIVE>>S, FB_H = V_ACTIVE>>S
ADDR_W, 15, RAM word-address width
DATA_W, 16, RAM word width
PIX_W, 8, bits per pixel; PACK = DATA_W/PIX_W must be a power of two
RAM_LAT, 1, RAM read latency in clk cycles (1 or 2)
BASE_RST, 0, active base address after reset

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous reset, active-low
pix_en  in  1  pixel tick; counters and pipeline advance only when high (tie high for pixel clock = clk)
fb_base  in  ADDR_W  new frame base word address
fb_base_wr  in  1  one-cycle strobe; capture fb_base as pending base
mem_addr  out  ADDR_W  RAM port-B word address (registered)
mem_rdata  in  DATA_W  RAM port-B read data
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
color  out  PIX_W  pixel value; 0 outside the active area
active  out  1  high when color is a visible pixel
frame_start  out  1  one-clk pulse on the pix_en tick where counters are at (0,0)
flip_done  out  1  one-clk pulse when a pending base is applied

Behaviour:
- Reset (rst_n low at an edge): h=v=0; active base = BASE_RST; no pending flip; mem_addr = BASE_RST; hsync = vsync = ~SYNC_POL; color = 0; active = 0; frame_start = 0; flip_done = 0. Reset overrides pix_en and is honoured mid-line.
- Counters: h runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters; v advances when h wraps; v wraps at V_TOTAL. Both advance on pix_en only.
- Visible when h < H_ACTIVE and v < V_ACTIVE.
- Sync timing:
  - hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted likewise in lines.
- Address generation (no multiplier):
  - row_base register = base + (v>>S)*(FB_W/PACK).
  - row_base advances by FB_W/PACK on the last tick of each line where (v mod 2^S) = 2^S-1 and v < V_ACTIVE.
  - row_base reloads to the active base at the frame wrap.
  - Pixel index px = h>>S; word = row_base + (px / PACK); lane = px mod PACK.
  - All address sums wrap modulo 2^ADDR_W.
  - mem_addr holds its value while pix_en is low.
- Pixel select: lane 0 = mem_rdata[PIX_W-1:0], ascending lanes upward.
- Pipeline alignment:
  - The lane, visible flag and sync flags are delayed by the same number of stages as the data path.
  - Counter position sampled at pix_en tick k appears on hsync/vsync/active/color at tick k+RAM_LAT+1.
  - With pix_en tied high this is exactly RAM_LAT+1 clk.
  - Sync, active and color are never mutually skewed.
- Page flip:
  - fb_base_wr loads the pending register and sets flip_pending; repeated writes before the boundary: last write wins.
  - At the frame-wrap tick (h = H_TOTAL-1, v = V_TOTAL-1, pix_en = 1) with flip_pending set: active base <= pending, flip_pending cleared, flip_done pulses for one clk.
  - A write in the same cycle as the wrap is applied at that wrap, using the newly written value.
  - The base never changes mid-frame.
- frame_start: combinational from the counter state, registered; one clk wide even when pix_en is high for consecutive cycles.

Test Plan:
Small config for all tests: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), S=1, PACK=2, RAM_LAT=1, pix_en=1.
- Reset mid-line (rst_n low at h=5) -> next cycle h=0, hsync=vsync=1, color=0, mem_addr=BASE_RST.
- Free run 2 frames -> hsync low exactly at h=10..11 of each line (shifted +2 clk at output); vsync low on line 5 only; line period 14 clk; frame period 98 clk.
- RAM model with word[n] = {n+0x80, n}, base=0 -> line 0 colors 0x00,0x00,0x80,0x80,0x01,0x01,0x81,0x81; lines 0 and 1 identical; line 2 starts with word 2.
- fb_base_wr with 0x100 at line 2 -> current frame unchanged; flip_done pulses at the wrap; next frame mem_addr starts at 0x100.
- fb_base_wr 0x200 then 0x300 before the wrap, and a second case with the write on the wrap cycle itself -> the last value (0x300, and the wrap-cycle value respectively) is applied at that wrap.
- pix_en every 3rd clk, base=0x7FFF -> timing stretched 3x; mem_addr wraps from 0x7FFF to 0x0000; outputs stable between ticks.
